ctr_buffer: RTL and testbench
=============================

# ctr_buffer

Circular record buffer of the Control Transfer Records (CTR) subsystem. It sits directly downstream of `ctr_emitter` inside `ctr_unit` and absorbs up to `NrCommitPorts` emitted records per cycle. It maintains the `sctrstatus.WRPTR` write pointer and honours the freeze and runtime-depth controls from `csr_regfile`. It serves indexed record reads for the `sireg*` CSR window.

## Interface

Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; supplies `NrCommitPorts`.
- `MaxDepth`, default 16: physical entry count; must be a power of two in 16..256.

Ports:
- `clk_i`  in  1  core clock; the block uses this one clock only.
- `rst_i`  in  1  reset, synchronous, active-high.
- `source_i`  in  `NrCommitPorts` x `ctrsource_rv_t`  emitted source words; bit 0 is the valid (V) bit.
- `target_i`  in  `NrCommitPorts` x `ctrtarget_rv_t`  emitted target words.
- `data_i`  in  `NrCommitPorts` x `ctrdata_rv_t`  emitted data words.
- `frozen_i`  in  1  `sctrstatus.FROZEN`.
- `depth_i`  in  3  `sctrdepth.DEPTH`; active depth is 16 << `depth_i`.
- `wrptr_we_i`  in  1  CSR write strobe for `sctrstatus.WRPTR`.
- `wrptr_wdata_i`  in  8  new WRPTR value.
- `wrptr_o`  out  8  current WRPTR.
- `clr_i`  in  1  `sctrclr` pulse.
- `busy_o`  out  1  clear sweep in progress.
- `rd_req_i`  in  1  read request.
- `rd_idx_i`  in  8  logical index; 0 is the newest record.
- `rd_valid_o`  out  1  read response strobe.
- `rd_source_o`, `rd_target_o`, `rd_data_o`  out  XLEN each  read response words.

## Operation

- **Active depth** D = min(16 << `depth_i`, `MaxDepth`). `depth_i` encodings above 4 clamp to `MaxDepth`.
- **Pointer width:** all pointer arithmetic is modulo D. `wrptr_o` is the masked pointer, with upper bits zero.
- **Record capture:** a port's record is valid when `source_i[i][0]` = 1.
  - Valid ports are compacted in port order; port 0 is the oldest.
  - The k-th valid port is written to physical entry (wrptr + k) mod D.
  - The pointer then advances by the count of valid ports, mod D.
- **Dropped records:** records are dropped when any of the following is true: `frozen_i`, `busy_o`, `clr_i`, or `wrptr_we_i`.
- **Priority:** `rst_i` > `clr_i` > `wrptr_we_i` > record capture.
- **Pointer write:** `wrptr_we_i` loads `wrptr_wdata_i` mod D. It is ignored while `busy_o` is high.
- **Depth change:** the pointer is re-masked to the new D on the next cycle. Entries are not cleared.
- **Read mapping:** logical index j maps to physical entry (wrptr - 1 - j) mod D.
  - If j >= D, or the entry's V bit is 0, all three response words are zero.
  - Reads issued while `busy_o` is high are answered with zeros.
- **FSM states:** two states, `IDLE` and `CLEAR`.
  - `IDLE` -> `CLEAR` on `clr_i`. On entry, wrptr is set to 0 and the sweep index is set to 0.
  - In `CLEAR`, one physical entry (all three words) is zeroed per cycle, counting up.
  - `CLEAR` -> `IDLE` after entry `MaxDepth`-1 is zeroed.
  - `clr_i` received during `CLEAR` restarts the sweep at index 0.

## Timing

- **Reset values:** `rst_i` puts the FSM in `CLEAR` with sweep index 0 and wrptr = 0.
  - `busy_o` = 1 for `MaxDepth` cycles after reset deasserts.
  - `wrptr_o` = 0, `rd_valid_o` = 0, and all read data outputs = 0.
  - Entries are cleared by this sweep; the storage array itself has no reset.
  - Reset asserted mid-sweep restarts the sweep.
- **Capture latency:** a record captured in cycle N is readable by a request made in cycle N+1. `wrptr_o` updates at the N+1 edge.
- **Read latency:** a request in cycle N produces `rd_valid_o` = 1 in N+1, for exactly one cycle. There is no back-pressure; a request may be issued every cycle.
- **Same-cycle read and write:** the index is resolved against the pre-update wrptr. Storage is read before that cycle's write, so the old contents are returned.
- **Clear latency:** `clr_i` in cycle N gives `busy_o` = 1 from N+1 through N+`MaxDepth`.

## Configuration

- **Macro `CTR_BUFFER_CSR_WRITE_EN`:** adds direct CSR writes to entries. The added ports are:
  - `wr_req_i` (1 bit).
  - `wr_idx_i` (8 bits).
  - `wr_sel_i` (2 bits: 0 = source, 1 = target, 2 = data, 3 = ignored).
  - `wr_wdata_i` (XLEN bits).
- **Write behaviour with the macro:**
  - `wr_idx_i` uses the same logical mapping as reads.
  - The write takes effect at the next edge.
  - Priority is below `wrptr_we_i` and above record capture.
  - A record capture in the same cycle is dropped.
  - The write is ignored when busy or when index >= D.
- **Without the macro:** these ports are absent, and entries are writable only by capture and the clear sweep.

## Structure

- **Shared package (`ctr_pkg`):** the entry struct `ctr_entry_t` (source, target, data), the constants `CtrMinDepth` = 16 and `CtrMaxDepthLimit` = 256, and the FSM enum `ctr_buf_state_e`.
- **Sub-module `ctr_buffer_compact`:** combinational. Computes, for each port, its write offset and the total valid-record count.
- **Integration:** `ctr_unit` instantiates `ctr_buffer` after `ctr_emitter`.

## Test plan

1. **Reset sweep:** reset with `MaxDepth`=16 -> `busy_o` high for 16 cycles; reads of idx 0..15 then return zeros; `wrptr_o`=0.
2. **Compaction:** D=16, 2 ports, both valid with sources 0x101 and 0x201 -> `wrptr_o`=2; idx 0 reads source 0x201 and idx 1 reads 0x101. With port 0 invalid and port 1 valid -> a single entry is written.
3. **Wrap-around:** 17 single records with source values 0x11..0x21 (low bit set) -> `wrptr_o`=1; idx 0 = 0x21; idx 15 = 0x13.
4. **Freeze and priority:** `frozen_i`=1 with valid records -> wrptr unchanged. `wrptr_we_i` with wdata 0x25 at D=16 and a valid record in the same cycle -> `wrptr_o`=5 and the record is dropped.
5. **Clear mid-operation:** `clr_i` at cycle 100, then `clr_i` again at cycle 105 -> `busy_o` stays high through cycle 105+`MaxDepth`. All reads during that window return zeros with `rd_valid_o`=1.
6. **Depth change:** `depth_i` goes 1 -> 0 with wrptr=20 -> `wrptr_o`=4; a read of idx 16 returns zeros.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration record consumed by the CTR blocks: register width and
// the number of commit ports that can retire (and emit a record) per cycle.
// No ports; the default value is what standalone CTR builds elaborate against.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned NrCommitPorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64, NrCommitPorts: 32'd2};

endpackage

// File: rtl/ctr_pkg.sv
// Shared CTR types: record words, the stored entry, buffer FSM states and
// depth helpers. No ports. Pointers and logical indices are 8 bits wide
// because the largest supported buffer holds 256 entries.
package ctr_pkg;

   localparam int unsigned CtrXlen          = config_pkg::cva6_cfg_empty.XLEN;
   localparam int unsigned CtrMinDepth      = 16;
   localparam int unsigned CtrMaxDepthLimit = 256;

   typedef logic [CtrXlen-1:0]                  ctrsource_rv_t;
   typedef logic [CtrXlen-1:0]                  ctrtarget_rv_t;
   typedef logic [CtrXlen-1:0]                  ctrdata_rv_t;
   typedef logic [$clog2(CtrMaxDepthLimit)-1:0] ctr_ptr_t;

   typedef struct packed {
      ctrsource_rv_t source;
      ctrtarget_rv_t target;
      ctrdata_rv_t   data;
   } ctr_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } ctr_buf_state_e;

   // Mask for active depth D = 16 << depth, with encodings beyond the
   // physical size clamped to max_sel. D is a power of two, so D-1 is the mask.
   function automatic ctr_ptr_t ctr_depth_mask(input logic [2:0] depth,
                                                input logic [2:0] max_sel);
      logic [2:0] sel;
      logic [8:0] size;
      sel  = (depth > max_sel) ? max_sel : depth;
      size = 9'(CtrMinDepth) << sel;
      return ctr_ptr_t'(size - 9'd1);
   endfunction

endpackage

// File: rtl/ctr_buffer_compact.sv
// Record compaction: for each commit port, the number of valid ports below
// it (its write offset from wrptr) and the total number of valid ports.
// Ports: valid (per-port V bits) in; offset (per port) and count out. Purely combinational.
module ctr_buffer_compact
   import ctr_pkg::*;
#(
   parameter int unsigned NrPorts = 2
) (
   input  logic                  [NrPorts-1:0] valid,
   output ctr_ptr_t [NrPorts-1:0]              offset,
   output ctr_ptr_t                            count
);

   always_comb begin
      count  = '0;
      offset = '0;
      // Running prefix count: port 0 is the oldest record, so it lands first.
      for (int i = 0; i < NrPorts; i++) begin
         offset[i] = count;
         count     = count + ctr_ptr_t'(valid[i]);
      end
   end

endmodule

// File: rtl/ctr_buffer.sv
// CTR circular record buffer: captures up to NrCommitPorts records per cycle at
// wrptr, owns sctrstatus.WRPTR, runs the clear sweep and serves indexed reads.
// Ports: clk_i/rst_i; source_i/target_i/data_i records; frozen_i, depth_i,
// wrptr_we_i/wrptr_wdata_i/wrptr_o, clr_i/busy_o; rd_req_i/rd_idx_i ->
// rd_valid_o + rd_source_o/rd_target_o/rd_data_o one cycle later.
// Optional macro CTR_BUFFER_CSR_WRITE_EN adds wr_req_i/wr_idx_i/wr_sel_i/wr_wdata_i
// for direct CSR writes to entries.
module ctr_buffer
   import ctr_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
   parameter int unsigned           MaxDepth = 16
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  ctrsource_rv_t [CVA6Cfg.NrCommitPorts-1:0]  source_i,
   input  ctrtarget_rv_t [CVA6Cfg.NrCommitPorts-1:0]  target_i,
   input  ctrdata_rv_t   [CVA6Cfg.NrCommitPorts-1:0]  data_i,
   input  logic                                       frozen_i,
   input  logic [2:0]                                 depth_i,
   input  logic                                       wrptr_we_i,
   input  logic [7:0]                                 wrptr_wdata_i,
   output logic [7:0]                                 wrptr_o,
   input  logic                                       clr_i,
   output logic                                       busy_o,
`ifdef CTR_BUFFER_CSR_WRITE_EN
   input  logic                                       wr_req_i,
   input  logic [7:0]                                 wr_idx_i,
   input  logic [1:0]                                 wr_sel_i,
   input  logic [CtrXlen-1:0]                         wr_wdata_i,
`endif
   input  logic                                       rd_req_i,
   input  logic [7:0]                                 rd_idx_i,
   output logic                                       rd_valid_o,
   output logic [CtrXlen-1:0]                         rd_source_o,
   output logic [CtrXlen-1:0]                         rd_target_o,
   output logic [CtrXlen-1:0]                         rd_data_o
);

   localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
   localparam int unsigned AW      = $clog2(MaxDepth);
   localparam logic [2:0]  MaxSel  = 3'($clog2(MaxDepth) - $clog2(CtrMinDepth));

   ctr_buf_state_e state;
   logic           busy;
   logic [AW-1:0]  sweep;
   ctr_ptr_t       wrptr;

   // Storage has no reset; the sweep that follows reset zeroes it.
   ctr_entry_t     mem [MaxDepth];

   ctr_ptr_t       mask;
   ctr_ptr_t       ptr;

   // The register is re-masked every cycle, but internal users mask again so a
   // depth shrink is honoured immediately by reads and captures.
   assign mask    = ctr_depth_mask(depth_i, MaxSel);
   assign ptr     = wrptr & mask;
   assign wrptr_o = wrptr;
   assign busy_o  = busy;

   // ------------------------------------------------------------------
   // Record compaction
   // ------------------------------------------------------------------
   logic     [NrPorts-1:0] rec_vld;
   ctr_ptr_t [NrPorts-1:0] rec_off;
   ctr_ptr_t               rec_cnt;

   always_comb begin
      rec_vld = '0;
      for (int i = 0; i < NrPorts; i++) rec_vld[i] = source_i[i][0];
   end

   ctr_buffer_compact #(
      .NrPorts (NrPorts)
   ) u_compact (
      .valid  (rec_vld),
      .offset (rec_off),
      .count  (rec_cnt)
   );

   // ------------------------------------------------------------------
   // Direct entry write (optional)
   // ------------------------------------------------------------------
   logic wr_take;
`ifdef CTR_BUFFER_CSR_WRITE_EN
   logic [AW-1:0] wr_phys;
   assign wr_take = wr_req_i && !busy && !clr_i && !wrptr_we_i && (wr_idx_i <= mask);
   assign wr_phys = AW'((ptr - 8'd1 - wr_idx_i) & mask);
`else
   assign wr_take = 1'b0;
`endif

   // Any higher-priority action in the cycle drops the whole capture group.
   logic cap_en;
   assign cap_en = !frozen_i && !busy && !clr_i && !wrptr_we_i && !wr_take;

   // ------------------------------------------------------------------
   // Control FSM and write pointer
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= CLEAR;
         busy  <= 1'b1;
         sweep <= '0;
         wrptr <= '0;
      end else if (clr_i) begin
         // Also restarts a sweep already in progress.
         state <= CLEAR;
         busy  <= 1'b1;
         sweep <= '0;
         wrptr <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (sweep == AW'(MaxDepth - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  sweep <= '0;
               end else begin
                  sweep <= sweep + AW'(1);
               end
            end
            default: ;
         endcase

         if (wrptr_we_i && !busy) begin
            wrptr <= wrptr_wdata_i & mask;
         end else if (cap_en) begin
            // D divides 256, so 8-bit wraparound followed by the mask is mod D.
            wrptr <= (ptr + rec_cnt) & mask;
         end else begin
            wrptr <= ptr;
         end
      end
   end

   // ------------------------------------------------------------------
   // Storage writes: sweep, direct write, capture (mutually exclusive)
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (busy) begin
         mem[sweep] <= '0;
`ifdef CTR_BUFFER_CSR_WRITE_EN
      end else if (wr_take) begin
         case (wr_sel_i)
            2'd0:    mem[wr_phys].source <= wr_wdata_i;
            2'd1:    mem[wr_phys].target <= wr_wdata_i;
            2'd2:    mem[wr_phys].data   <= wr_wdata_i;
            default: ;
         endcase
`endif
      end else if (cap_en) begin
         for (int i = 0; i < NrPorts; i++) begin
            if (rec_vld[i]) begin
               mem[AW'((ptr + rec_off[i]) & mask)] <= '{source: source_i[i],
                                                        target: target_i[i],
                                                        data:   data_i[i]};
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read port: index 0 is the newest record, i.e. the slot just below wrptr.
   // Storage is sampled before this edge's write, so a same-cycle capture is
   // not visible until the next request.
   // ------------------------------------------------------------------
   logic [AW-1:0] rd_phys;
   ctr_entry_t    rd_ent;
   logic          rd_hit;

   assign rd_phys = AW'((ptr - 8'd1 - rd_idx_i) & mask);
   assign rd_ent  = mem[rd_phys];
   assign rd_hit  = !busy && (rd_idx_i <= mask) && rd_ent.source[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_o  <= 1'b0;
         rd_source_o <= '0;
         rd_target_o <= '0;
         rd_data_o   <= '0;
      end else begin
         rd_valid_o <= rd_req_i;
         if (rd_req_i && rd_hit) begin
            rd_source_o <= rd_ent.source;
            rd_target_o <= rd_ent.target;
            rd_data_o   <= rd_ent.data;
         end else begin
            rd_source_o <= '0;
            rd_target_o <= '0;
            rd_data_o   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ctr_buffer.sv
// Directed bench for ctr_buffer (MaxDepth 32, two commit ports): reset sweep,
// compaction/priority vectors, wrap-around, same-cycle read/write, restarted
// clear, depth change and depth clamping.
module tb_ctr_buffer;
   import ctr_pkg::*;

   localparam int MD = 32;

   logic                      clk;
   logic                      rst;
   ctrsource_rv_t [1:0]       source;
   ctrtarget_rv_t [1:0]       target;
   ctrdata_rv_t   [1:0]       data;
   logic                      frozen;
   logic [2:0]                depth;
   logic                      wrptr_we;
   logic [7:0]                wrptr_wdata;
   logic [7:0]                wrptr;
   logic                      clr;
   logic                      busy;
   logic                      rd_req;
   logic [7:0]                rd_idx;
   logic                      rd_valid;
   logic [CtrXlen-1:0]        rd_source;
   logic [CtrXlen-1:0]        rd_target;
   logic [CtrXlen-1:0]        rd_data;

   int n_cmp  = 0;
   int n_fail = 0;

   ctr_buffer #(
      .MaxDepth (MD)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .source_i      (source),
      .target_i      (target),
      .data_i        (data),
      .frozen_i      (frozen),
      .depth_i       (depth),
      .wrptr_we_i    (wrptr_we),
      .wrptr_wdata_i (wrptr_wdata),
      .wrptr_o       (wrptr),
      .clr_i         (clr),
      .busy_o        (busy),
      .rd_req_i      (rd_req),
      .rd_idx_i      (rd_idx),
      .rd_valid_o    (rd_valid),
      .rd_source_o   (rd_source),
      .rd_target_o   (rd_target),
      .rd_data_o     (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  depth;
      logic        frz;
      logic        we;
      logic [7:0]  wd;
      logic [63:0] s0;
      logic [63:0] s1;
      logic [7:0]  exp_ptr;
   } vec_t;

   typedef struct {
      logic [7:0]  idx;
      logic [63:0] exp_src;
   } rdv_t;

   vec_t vt1 [6];
   vec_t vt2 [6];
   rdv_t rt  [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_rec(input int port, input logic [63:0] s);
      source[port] = s;
      target[port] = s + 64'h1000;
      data[port]   = s + 64'h2000;
   endtask

   task automatic idle_inputs();
      set_rec(0, 64'h0);
      set_rec(1, 64'h0);
      frozen   = 1'b0;
      wrptr_we = 1'b0;
      clr      = 1'b0;
      rd_req   = 1'b0;
   endtask

   // One cycle of stimulus, then the pointer is compared.
   task automatic apply_vec(input string name, input vec_t v);
      depth       = v.depth;
      frozen      = v.frz;
      wrptr_we    = v.we;
      wrptr_wdata = v.wd;
      set_rec(0, v.s0);
      set_rec(1, v.s1);
      @(negedge clk);
      idle_inputs();
      chk({name, ".wrptr"}, 64'(wrptr), 64'(v.exp_ptr));
   endtask

   // A zero expected source means an empty/blocked read: all words zero.
   task automatic rd_chk(input string name, input logic [7:0] idx, input logic [63:0] exp_src);
      logic [63:0] et, ed;
      et = (exp_src == 64'h0) ? 64'h0 : exp_src + 64'h1000;
      ed = (exp_src == 64'h0) ? 64'h0 : exp_src + 64'h2000;
      rd_req = 1'b1;
      rd_idx = idx;
      @(negedge clk);
      rd_req = 1'b0;
      chk({name, ".vld"}, 64'(rd_valid), 64'h1);
      chk({name, ".src"}, rd_source, exp_src);
      chk({name, ".tgt"}, rd_target, et);
      chk({name, ".dat"}, rd_data, ed);
   endtask

   initial begin
      int cnt;

      // D=16 compaction and priority vectors; pointer starts at 0 after reset.
      vt1[0] = '{3'd0, 1'b0, 1'b0, 8'h00, 64'h101, 64'h201, 8'd2};
      vt1[1] = '{3'd0, 1'b0, 1'b0, 8'h00, 64'h300, 64'h401, 8'd3};
      vt1[2] = '{3'd0, 1'b1, 1'b0, 8'h00, 64'h501, 64'h601, 8'd3};
      vt1[3] = '{3'd0, 1'b0, 1'b1, 8'h25, 64'h701, 64'h000, 8'd5};
      vt1[4] = '{3'd0, 1'b0, 1'b0, 8'h00, 64'h801, 64'h000, 8'd6};
      vt1[5] = '{3'd0, 1'b0, 1'b0, 8'h00, 64'h300, 64'h200, 8'd6};
      // Physical 0..5 = 101,201,401,0,0,801; wrptr 6.
      rt[0] = '{8'd0,  64'h801};
      rt[1] = '{8'd1,  64'h0};
      rt[2] = '{8'd2,  64'h0};
      rt[3] = '{8'd3,  64'h401};
      rt[4] = '{8'd4,  64'h201};
      rt[5] = '{8'd5,  64'h101};
      rt[6] = '{8'd6,  64'h0};
      rt[7] = '{8'd16, 64'h0};
      // Depth change: records at physical 3 and 19 with D=32, then shrink to 16.
      vt2[0] = '{3'd1, 1'b0, 1'b1, 8'd3,  64'h0,   64'h0, 8'd3};
      vt2[1] = '{3'd1, 1'b0, 1'b0, 8'd0,  64'hA01, 64'h0, 8'd4};
      vt2[2] = '{3'd1, 1'b0, 1'b1, 8'd19, 64'h0,   64'h0, 8'd19};
      vt2[3] = '{3'd1, 1'b0, 1'b0, 8'd0,  64'h901, 64'h0, 8'd20};
      vt2[4] = '{3'd0, 1'b0, 1'b0, 8'd0,  64'h0,   64'h0, 8'd4};
      vt2[5] = '{3'd7, 1'b0, 1'b1, 8'h37, 64'h0,   64'h0, 8'h17};

      rst         = 1'b1;
      depth       = 3'd0;
      wrptr_wdata = 8'h00;
      rd_idx      = 8'h00;
      idle_inputs();

      // ---- reset state and sweep length ----
      repeat (3) @(negedge clk);
      chk("rst.wrptr", 64'(wrptr), 64'h0);
      chk("rst.busy", 64'(busy), 64'h1);
      chk("rst.rd_valid", 64'(rd_valid), 64'h0);
      chk("rst.rd_source", rd_source, 64'h0);
      rst = 1'b0;
      cnt = 0;
      while (busy && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      chk("rst.busy_cycles", 64'(cnt), 64'(MD));
      chk("rst.wrptr_after", 64'(wrptr), 64'h0);
      rd_chk("rst.rd0", 8'd0, 64'h0);
      rd_chk("rst.rd15", 8'd15, 64'h0);

      // ---- compaction, freeze, pointer-write priority ----
      for (int i = 0; i < 6; i++) apply_vec($sformatf("vt1[%0d]", i), vt1[i]);
      for (int i = 0; i < 8; i++) rd_chk($sformatf("rt[%0d]", i), rt[i].idx, rt[i].exp_src);
      @(negedge clk);
      chk("rd_valid.single", 64'(rd_valid), 64'h0);

      // ---- wrap-around: 17 single records from pointer 0 ----
      apply_vec("wrap.zero", '{3'd0, 1'b0, 1'b1, 8'd0, 64'h0, 64'h0, 8'd0});
      for (int k = 0; k < 17; k++) begin
         set_rec(0, (64'h11 + 64'(k)) | 64'h1);
         @(negedge clk);
         idle_inputs();
      end
      chk("wrap.wrptr", 64'(wrptr), 64'h1);
      rd_chk("wrap.rd0", 8'd0, 64'h21);
      rd_chk("wrap.rd1", 8'd1, 64'h21);
      rd_chk("wrap.rd2", 8'd2, 64'h1F);
      rd_chk("wrap.rd15", 8'd15, 64'h13);

      // ---- same-cycle read and capture: old newest record is returned ----
      set_rec(0, 64'h51);
      rd_req = 1'b1;
      rd_idx = 8'd0;
      @(negedge clk);
      idle_inputs();
      chk("rw.old_src", rd_source, 64'h21);
      chk("rw.wrptr", 64'(wrptr), 64'h2);
      rd_chk("rw.new", 8'd0, 64'h51);

      // ---- clear, pointer write ignored while busy, clear restarted ----
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr.busy", 64'(busy), 64'h1);
      wrptr_we    = 1'b1;
      wrptr_wdata = 8'd9;
      set_rec(0, 64'h61);
      @(negedge clk);
      idle_inputs();
      chk("clr.we_ignored", 64'(wrptr), 64'h0);
      repeat (3) @(negedge clk);
      chk("clr.busy_before_restart", 64'(busy), 64'h1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cnt = 0;
      while (busy && cnt < 1000) begin
         cnt++;
         rd_req = 1'b1;
         rd_idx = 8'(cnt % 16);
         @(negedge clk);
         rd_req = 1'b0;
         chk($sformatf("clr.rd%0d.vld", cnt), 64'(rd_valid), 64'h1);
         chk($sformatf("clr.rd%0d.src", cnt), rd_source, 64'h0);
      end
      chk("clr.busy_cycles", 64'(cnt), 64'(MD));
      chk("clr.wrptr", 64'(wrptr), 64'h0);
      rd_chk("clr.rd0", 8'd0, 64'h0);
      rd_chk("clr.rd14", 8'd14, 64'h0);

      // ---- depth change and clamping ----
      for (int i = 0; i < 5; i++) apply_vec($sformatf("vt2[%0d]", i), vt2[i]);
      rd_chk("depth.rd16", 8'd16, 64'h0);
      rd_chk("depth.rd0", 8'd0, 64'hA01);
      apply_vec("vt2[5]", vt2[5]);
      rd_chk("clamp.rd3", 8'd3, 64'h901);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
